dcache_wb_buffer: RTL and testbench

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

---
 rtl/dcache_wb_buffer.sv | 166 ++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer for dirty D-cache victims: circular FIFO that coalesces
// repeated victims, answers load-miss lookups and drains to memory via STOREs.
//
// state | meaning
// IDLE  | buffer empty, no flush pending
// DRAIN | entries waiting to be stored to memory
// FLUSH | draining everything; new victims refused
module dcache_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    evict_valid,
    input  logic                    evict_dirty,
    input  logic [ADDR_W-1:0]       evict_addr,
    input  logic [63:0]             evict_data,
    output logic                    evict_ready,
    input  logic [ADDR_W-1:0]       lk_addr,
    output logic                    lk_hit,
    output logic [63:0]             lk_data,
    input  logic                    mem_grant,
    output logic [1:0]              mem_cmd,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [63:0]             mem_data,
    input  logic [3:0]              mem_response,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ADDR_W - 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TW-1:0]     addr_q [DEPTH];
    logic [TW-1:0]     addr_d [DEPTH];
    logic [63:0]       data_q [DEPTH];
    logic [63:0]       data_d [DEPTH];

    logic              store, pop, push, match, push_new, coalesce;
    logic [PW-1:0]     match_idx;
    logic [TW-1:0]     ev_tag, lk_tag;
    logic              unused_low_bits;

    assign ev_tag          = evict_addr[ADDR_W-1:3];
    assign lk_tag          = lk_addr[ADDR_W-1:3];
    assign unused_low_bits = ^{evict_addr[2:0], lk_addr[2:0]};

    assign store    = (count_q != '0) && mem_grant;
    assign pop      = store && (mem_response != 4'd0);
    assign push     = evict_valid && evict_dirty && evict_ready;
    assign push_new = push && !match;
    assign coalesce = push && match;

    assign mem_cmd  = store ? CMD_STORE : CMD_NONE;
    assign mem_addr = store ? {addr_q[head_q], 3'b000} : '0;
    assign mem_data = store ? data_q[head_q] : '0;
    assign count    = count_q;

    // A head leaving this cycle cannot absorb a victim; it goes to the tail instead.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == ev_tag && !(pop && PW'(i) == head_q)) begin
                match     = 1'b1;
                match_idx = PW'(i);
            end
        end
    end

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == lk_tag) begin
                lk_hit  = 1'b1;
                lk_data = data_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (coalesce) begin
            data_d[match_idx] = evict_data;
        end
        if (push_new) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = ev_tag;
            data_d[tail_q]  = evict_data;
            tail_d          = tail_q + 1'b1;
        end
        if (push_new && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_new) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FLUSH holds while flush stays high so flush_done remains visible.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (push) state_d = S_DRAIN;
                S_DRAIN: if (count_d == '0) state_d = S_IDLE;
                S_FLUSH: if (count_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        evict_ready = (count_q < DEPTH_C) && (state_q != S_FLUSH);
        flush_done  = (state_q == S_IDLE && !flush) ||
                      (state_q == S_FLUSH && count_q == '0);
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the buffer.
module tb_dcache_wb_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              evict_valid, evict_dirty;
    logic [ADDR_W-1:0] evict_addr;
    logic [63:0]       evict_data;
    logic              evict_ready;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [63:0]       lk_data;
    logic              mem_grant;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_data;
    logic [3:0]        mem_response;
    logic              flush;
    logic              flush_done;
    logic [2:0]        count;

    always #5 clock = ~clock;

    dcache_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .evict_valid(evict_valid), .evict_dirty(evict_dirty),
        .evict_addr(evict_addr), .evict_data(evict_data), .evict_ready(evict_ready),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .mem_grant(mem_grant), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_response(mem_response),
        .flush(flush), .flush_done(flush_done), .count(count)
    );

    typedef struct {
        logic [ADDR_W-4:0] tag;
        logic [63:0]       data;
    } ent_t;

    ent_t mq[$];
    bit   m_flush;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        int          n;
        bit          exp_store, exp_hit;
        logic [63:0] exp_addr, exp_data, exp_lk;
        n         = mq.size();
        exp_store = (n > 0) && mem_grant;
        exp_addr  = exp_store ? {mq[0].tag, 3'b000} : 64'd0;
        exp_data  = exp_store ? mq[0].data : 64'd0;
        exp_hit   = 1'b0;
        exp_lk    = 64'd0;
        foreach (mq[i]) begin
            if (mq[i].tag == lk_addr[ADDR_W-1:3]) begin
                exp_hit = 1'b1;
                exp_lk  = mq[i].data;
            end
        end
        chk("evict_ready", 64'(evict_ready), 64'((n < DEPTH) && !m_flush));
        chk("count", 64'(count), 64'(n));
        chk("mem_cmd", 64'(mem_cmd), exp_store ? 64'd2 : 64'd0);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_data", mem_data, exp_data);
        chk("lk_hit", 64'(lk_hit), 64'(exp_hit));
        chk("lk_data", lk_data, exp_lk);
        chk("flush_done", 64'(flush_done), 64'((n == 0) && (m_flush || !flush)));
    endtask

    task automatic model_update();
        int n, idx;
        bit pop, push;
        if (reset) begin
            mq.delete();
            m_flush = 1'b0;
        end else begin
            n    = mq.size();
            pop  = (n > 0) && mem_grant && (mem_response != 4'd0);
            push = evict_valid && evict_dirty && (n < DEPTH) && !m_flush;
            idx  = -1;
            if (push) begin
                for (int i = (pop ? 1 : 0); i < n; i++) begin
                    if (mq[i].tag == evict_addr[ADDR_W-1:3]) idx = i;
                end
            end
            if (push && idx >= 0) mq[idx].data = evict_data;
            if (pop) void'(mq.pop_front());
            if (push && idx < 0) mq.push_back('{tag: evict_addr[ADDR_W-1:3], data: evict_data});
            if (flush) m_flush = 1'b1;
            else if (m_flush && n == 0) m_flush = 1'b0;
        end
    endtask

    task automatic cycle();
        #1;
        compare_all();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle_in();
        reset        = 1'b0;
        evict_valid  = 1'b0;
        evict_dirty  = 1'b0;
        evict_addr   = '0;
        evict_data   = '0;
        lk_addr      = '0;
        mem_grant    = 1'b0;
        mem_response = 4'd0;
        flush        = 1'b0;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d);
        evict_valid = 1'b1;
        evict_dirty = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        cycle();
        evict_valid = 1'b0;
    endtask

    task automatic push_pop(input logic [63:0] a, input logic [63:0] d);
        mem_grant    = 1'b1;
        mem_response = 4'd1;
        push(a, d);
        mem_grant    = 1'b0;
        mem_response = 4'd0;
    endtask

    task automatic drain();
        mem_grant    = 1'b1;
        mem_response = 4'd1;
        for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) cycle();
        mem_grant    = 1'b0;
        mem_response = 4'd0;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(evict_ready), 64'd1);
        chk("rst_flush_done", 64'(flush_done), 64'd1);
        chk("rst_count", 64'(count), 64'd0);

        // store held while memory stalls, popped on the accept edge
        push(64'h1000, 64'hAAAA);
        mem_grant = 1'b1;
        cycle();
        cycle();
        mem_response = 4'd3;
        #1;
        chk("t31_cmd", 64'(mem_cmd), 64'd2);
        chk("t31_count_before", 64'(count), 64'd1);
        cycle();
        mem_grant    = 1'b0;
        mem_response = 4'd0;
        #1;
        chk("t31_count_after", 64'(count), 64'd0);

        // fill to capacity, overflow ignored, one pop reopens
        push(64'h100, 64'h1);
        push(64'h108, 64'h2);
        push(64'h110, 64'h3);
        push(64'h118, 64'h4);
        #1;
        chk("t32_count_full", 64'(count), 64'd4);
        chk("t32_ready_full", 64'(evict_ready), 64'd0);
        push(64'h120, 64'h5);
        #1;
        chk("t32_count_5th", 64'(count), 64'd4);
        mem_grant    = 1'b1;
        mem_response = 4'd1;
        cycle();
        mem_grant    = 1'b0;
        mem_response = 4'd0;
        #1;
        chk("t32_ready_after_pop", 64'(evict_ready), 64'd1);
        drain();

        // coalescing and lookup; clean victims leave no trace
        push(64'h200, 64'h11);
        push(64'h200, 64'h22);
        evict_dirty = 1'b0;
        evict_valid = 1'b1;
        evict_addr  = 64'h208;
        cycle();
        evict_valid = 1'b0;
        lk_addr = 64'h200;
        #1;
        chk("t33_count", 64'(count), 64'd1);
        chk("t33_hit", 64'(lk_hit), 64'd1);
        chk("t33_data", lk_data, 64'h22);

        // push during pop: count holds; victim matching the leaving head is new
        push(64'h300, 64'h33);
        push_pop(64'h308, 64'h44);
        #1;
        chk("t34_count", 64'(count), 64'd2);
        push_pop(64'h300, 64'h55);
        #1;
        chk("t21_count", 64'(count), 64'd2);
        lk_addr = 64'h300;
        #1;
        chk("t21_data", lk_data, 64'h55);
        drain();

        // flush drains in order and refuses victims
        push(64'h400, 64'h61);
        push(64'h408, 64'h62);
        push(64'h410, 64'h63);
        flush = 1'b1;
        cycle();
        mem_grant    = 1'b1;
        mem_response = 4'd1;
        evict_valid  = 1'b1;
        evict_dirty  = 1'b1;
        evict_addr   = 64'h418;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t35_ready", 64'(evict_ready), 64'd0);
            cycle();
        end
        evict_valid = 1'b0;
        #1;
        chk("t35_flush_done", 64'(flush_done), 64'd1);
        chk("t35_count", 64'(count), 64'd0);
        flush = 1'b0;
        cycle();
        mem_grant    = 1'b0;
        mem_response = 4'd0;

        // reset mid-drain discards everything, including a same-cycle push
        push(64'h500, 64'h71);
        push(64'h508, 64'h72);
        push(64'h510, 64'h73);
        mem_grant   = 1'b1;
        reset       = 1'b1;
        evict_valid = 1'b1;
        evict_dirty = 1'b1;
        evict_addr  = 64'h518;
        cycle();
        reset       = 1'b0;
        evict_valid = 1'b0;
        #1;
        chk("t36_count", 64'(count), 64'd0);
        chk("t36_cmd", 64'(mem_cmd), 64'd0);
        for (int k = 0; k < 4; k++) begin
            lk_addr = 64'h500 + 64'(k * 8);
            #0.5;
            chk("t36_hit", 64'(lk_hit), 64'd0);
        end
        cycle();
        mem_grant = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            evict_valid  = ($urandom_range(0, 1) == 1);
            evict_dirty  = ($urandom_range(0, 3) != 0);
            evict_addr   = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd8;
            evict_data   = {$urandom, $urandom};
            lk_addr      = 64'h1000 + 64'($urandom_range(0, 9)) * 64'd8 + 64'($urandom_range(0, 7));
            mem_grant    = ($urandom_range(0, 3) != 0);
            mem_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            flush        = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
